// File: rtl/toymips_pkg.sv
// Shared toyMIPS definitions: ALU op codes, conditional-move selectors and
// the EX/MEM trap FSM state encoding.
package toymips_pkg;

  // fu_alu operation codes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDU = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b1010;

  // Conditional-move selector; 2'b11 is reserved and behaves like MC_NONE
  localparam logic [1:0] MC_NONE = 2'b00;
  localparam logic [1:0] MC_MOVZ = 2'b01;
  localparam logic [1:0] MC_MOVN = 2'b10;

  // Trap FSM: RUN accepts results, TRAP stalls EX until the trap is acknowledged
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ex_mem_stage_sat_counter.sv
// Saturating up-counter used for the retired-instruction and trap statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Next count value, sticking at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) begin
      return val;
    end
    return val + 1'b1;
  endfunction

  // Count increments, clearing on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/alu_ex_mem_stage.sv
// EX/MEM boundary register for toyMIPS: captures fu_alu results, resolves the
// conditional-move write enable and the ADD/SUB overflow trap, and feeds the
// registered entry back to EX for forwarding.
module alu_ex_mem_stage
  import toymips_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_move_check,
  input  logic [3:0]        alu_op,
  input  logic [1:0]        move_cond,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       pc,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_result,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  output logic              out_zero,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [31:0]       fwd_data,
  output logic              exc_valid,
  output logic [31:0]       exc_pc,
  input  logic              exc_ack,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  trap_cnt
);

  state_t              state_p1;
  logic                vld_p1;
  logic                wen_p1;
  logic signed [31:0]  result_p1;
  logic [ADDR_W-1:0]   rd_p1;
  logic                zero_p1;
  logic                exc_vld_p1;
  logic [31:0]         exc_pc_p1;

  logic                move_ok_p0;
  logic                trap_p0;
  logic                wen_p0;
  logic                accept_p0;
  logic                handshake;

  // Conditional moves only write when fu_alu reports the condition held
  always_comb begin
    move_ok_p0 = 1'b1;
    case (move_cond)
      MC_MOVZ, MC_MOVN: move_ok_p0 = alu_move_check;
      default:          move_ok_p0 = 1'b1;
    endcase
  end

  // Only the signed ops trap on overflow; the trapping entry becomes a bubble
  assign trap_p0   = alu_overflow && ((alu_op == OP_ADD) || (alu_op == OP_SUB));
  assign wen_p0    = (rd_addr != '0) && !trap_p0 && move_ok_p0;

  assign in_ready  = (state_p1 == ST_RUN) && !flush && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready;
  assign handshake = vld_p1 && out_ready;

  // ---- EX -> MEM register boundary ----
  // Entry register, trap latch and FSM; flush beats ack and new input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= ST_RUN;
      vld_p1     <= 1'b0;
      wen_p1     <= 1'b0;
      result_p1  <= '0;
      rd_p1      <= '0;
      zero_p1    <= 1'b0;
      exc_vld_p1 <= 1'b0;
      exc_pc_p1  <= '0;
    end else if (flush) begin
      state_p1   <= ST_RUN;
      vld_p1     <= 1'b0;
      wen_p1     <= 1'b0;
      exc_vld_p1 <= 1'b0;
    end else begin
      if (accept_p0) begin
        vld_p1    <= 1'b1;
        wen_p1    <= wen_p0;
        result_p1 <= alu_result;
        rd_p1     <= rd_addr;
        zero_p1   <= alu_zero;
        if (trap_p0) begin
          exc_vld_p1 <= 1'b1;
          exc_pc_p1  <= pc;
          state_p1   <= ST_TRAP;
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
        wen_p1 <= 1'b0;
      end
      // accept never happens in TRAP, so this cannot collide with a new trap
      if ((state_p1 == ST_TRAP) && exc_ack) begin
        exc_vld_p1 <= 1'b0;
        state_p1   <= ST_RUN;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_result = result_p1;
  assign out_rd     = rd_p1;
  assign out_wen    = wen_p1;
  assign out_zero   = zero_p1;
  assign fwd_valid  = vld_p1 && wen_p1;
  assign fwd_rd     = rd_p1;
  assign fwd_data   = result_p1;
  assign exc_valid  = exc_vld_p1;
  assign exc_pc     = exc_pc_p1;

  sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (handshake),
    .count (retired_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_trap_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept_p0 && trap_p0),
    .count (trap_cnt)
  );

endmodule

// File: tb/tb_alu_ex_mem_stage.sv
// Scoreboard bench for alu_ex_mem_stage: stimulus pushes expected MEM entries,
// a negedge monitor pops and compares them on every out_valid/out_ready beat.
module tb_alu_ex_mem_stage;
  import toymips_pkg::*;

  localparam int CNT_W  = 5;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       alu_result;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_move_check;
  logic [3:0]        alu_op;
  logic [1:0]        move_cond;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       pc;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [31:0]       out_result;
  logic [ADDR_W-1:0] out_rd;
  logic              out_wen;
  logic              out_zero;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd;
  logic [31:0]       fwd_data;
  logic              exc_valid;
  logic [31:0]       exc_pc;
  logic              exc_ack;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  trap_cnt;

  typedef struct {
    logic [31:0]       res;
    logic [ADDR_W-1:0] rd;
    logic              wen;
    logic              zero;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_ex_mem_stage #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .alu_overflow   (alu_overflow),
    .alu_move_check (alu_move_check),
    .alu_op         (alu_op),
    .move_cond      (move_cond),
    .rd_addr        (rd_addr),
    .pc             (pc),
    .flush          (flush),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wen        (out_wen),
    .out_zero       (out_zero),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .exc_ack        (exc_ack),
    .retired_cnt    (retired_cnt),
    .trap_cnt       (trap_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one instruction, wait for acceptance, optionally record its expected entry
  task automatic send(input logic [3:0] op, input logic [31:0] res, input logic ovf,
                      input logic [1:0] mc, input logic mchk, input logic [ADDR_W-1:0] rd,
                      input logic [31:0] pcv, input logic exp_wen, input logic do_push);
    bit done = 0;
    exp_t e;
    alu_op = op; alu_result = res; alu_zero = (res == 32'd0); alu_overflow = ovf;
    move_cond = mc; alu_move_check = mchk; rd_addr = rd; pc = pcv; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (do_push) begin
          e.res = res; e.rd = rd; e.wen = exp_wen; e.zero = (res == 32'd0);
          sb.push_back(e);
        end
        done = 1;
      end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; alu_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every MEM handshake must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: out_result 0x%0h delivered, expected none", out_result);
        end else begin
          e = sb.pop_front();
          check("out_result", out_result, e.res);
          check("out_rd", 32'(out_rd), 32'(e.rd));
          check("out_wen", 32'(out_wen), 32'(e.wen));
          check("out_zero", 32'(out_zero), 32'(e.zero));
          check("fwd_valid", 32'(fwd_valid), 32'(e.wen));
          check("fwd_rd", 32'(fwd_rd), 32'(e.rd));
          check("fwd_data", fwd_data, e.res);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_result = '0; alu_zero = 1'b0; alu_overflow = 1'b0;
    alu_move_check = 1'b0; alu_op = OP_ADD; move_cond = MC_NONE; rd_addr = '0; pc = '0;
    flush = 1'b0; out_ready = 1'b1; exc_ack = 1'b0;
    idle(2);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_wen", 32'(out_wen), 0);
    check("rst_fwd_valid", 32'(fwd_valid), 0);
    check("rst_exc_valid", 32'(exc_valid), 0);
    check("rst_exc_pc", exc_pc, 0);
    check("rst_retired", 32'(retired_cnt), 0);
    check("rst_trap_cnt", 32'(trap_cnt), 0);
    rst = 1'b0;
    idle(1);

    // Normal ADD, then counter after the handshake
    send(OP_ADD, 32'd79, 1'b0, MC_NONE, 1'b0, 5'd3, 32'h10, 1'b1, 1'b1);
    check("add_out_valid", 32'(out_valid), 1);
    idle(2);
    check("add_retired", 32'(retired_cnt), 1);

    // Unsigned overflow never traps
    send(OP_ADDU, 32'd5, 1'b1, MC_NONE, 1'b0, 5'd4, 32'h14, 1'b1, 1'b1);
    check("addu_no_exc", 32'(exc_valid), 0);
    send(OP_SUBU, 32'hFFFF_FFF0, 1'b1, MC_NONE, 1'b0, 5'd4, 32'h18, 1'b1, 1'b1);
    check("subu_no_exc", 32'(exc_valid), 0);

    // Conditional moves, rd=0 and reserved move_cond
    send(OP_OR, 32'd21, 1'b0, MC_MOVZ, 1'b0, 5'd5, 32'h1C, 1'b0, 1'b1);
    send(OP_OR, 32'd22, 1'b0, MC_MOVZ, 1'b1, 5'd6, 32'h20, 1'b1, 1'b1);
    send(OP_OR, 32'd23, 1'b0, MC_MOVN, 1'b1, 5'd7, 32'h24, 1'b1, 1'b1);
    send(OP_AND, 32'd0, 1'b0, MC_NONE, 1'b0, 5'd0, 32'h28, 1'b0, 1'b1);
    send(OP_SLT, 32'd1, 1'b0, 2'b11, 1'b0, 5'd8, 32'h2C, 1'b1, 1'b1);
    idle(2);
    check("moves_retired", 32'(retired_cnt), 8);

    // Backpressure: entry A held for three cycles while B waits
    out_ready = 1'b0;
    send(OP_ADD, 32'd100, 1'b0, MC_NONE, 1'b0, 5'd11, 32'h200, 1'b1, 1'b1);
    alu_result = 32'd200; alu_zero = 1'b0; rd_addr = 5'd12; alu_op = OP_ADD;
    move_cond = MC_NONE; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_result", out_result, 32'd100);
      check("bp_hold_rd", 32'(out_rd), 32'd11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 1);
    begin
      exp_t e;
      e.res = 32'd200; e.rd = 5'd12; e.wen = 1'b1; e.zero = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);
    check("bp_retired", 32'(retired_cnt), 10);

    // Signed ADD overflow traps; EX is stalled until the ack
    send(OP_ADD, 32'h8000_0000, 1'b1, MC_NONE, 1'b0, 5'd9, 32'h40, 1'b0, 1'b1);
    check("trap_exc_valid", 32'(exc_valid), 1);
    check("trap_exc_pc", exc_pc, 32'h40);
    check("trap_cnt_1", 32'(trap_cnt), 1);
    alu_result = 32'd3; rd_addr = 5'd2; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("trap_in_ready", 32'(in_ready), 0);
      check("trap_exc_hold", 32'(exc_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; exc_ack = 1'b1;
    idle(1);
    exc_ack = 1'b0;
    check("ack_exc_valid", 32'(exc_valid), 0);
    @(negedge clk);
    check("ack_in_ready", 32'(in_ready), 1);
    idle(1);

    // Flush in TRAP beats simultaneous ack and new input
    send(OP_SUB, 32'd5, 1'b1, MC_NONE, 1'b0, 5'd13, 32'h80, 1'b0, 1'b1);
    idle(2);
    check("trap2_exc_valid", 32'(exc_valid), 1);
    check("trap2_exc_pc", exc_pc, 32'h80);
    check("trap_cnt_2", 32'(trap_cnt), 2);
    flush = 1'b1; exc_ack = 1'b1; in_valid = 1'b1;
    alu_result = 32'd77; rd_addr = 5'd14; alu_op = OP_ADD; alu_overflow = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; exc_ack = 1'b0; in_valid = 1'b0;
    check("flush_exc_valid", 32'(exc_valid), 0);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_fwd_valid", 32'(fwd_valid), 0);
    @(negedge clk);
    check("flush_run_ready", 32'(in_ready), 1);
    idle(1);
    check("flush_retired", 32'(retired_cnt), 12);
    check("flush_trap_cnt", 32'(trap_cnt), 2);

    // Reset in the middle of a trap with an undelivered bubble
    out_ready = 1'b0;
    send(OP_ADD, 32'h7FFF_FFFF, 1'b1, MC_NONE, 1'b0, 5'd10, 32'h100, 1'b0, 1'b0);
    check("pre_rst_exc_valid", 32'(exc_valid), 1);
    check("pre_rst_out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    idle(1);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_result", out_result, 0);
    check("mid_rst_exc_valid", 32'(exc_valid), 0);
    check("mid_rst_exc_pc", exc_pc, 0);
    check("mid_rst_retired", 32'(retired_cnt), 0);
    check("mid_rst_trap_cnt", 32'(trap_cnt), 0);
    rst = 1'b0; out_ready = 1'b1;
    idle(1);

    // Counter saturation at all-ones (31 for the 5-bit bench instance)
    for (int i = 0; i < 40; i++) begin
      send(OP_OR, 32'(i + 1), 1'b0, MC_NONE, 1'b0, 5'(1 + (i % 31)), 32'(i * 4), 1'b1, 1'b1);
    end
    idle(3);
    check("sat_retired", 32'(retired_cnt), 31);
    check("sat_trap_cnt", 32'(trap_cnt), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
